// File: rtl/stepper_pulse_gen.sv
// stepper_pulse_gen: STEP/DIR pulse generator for one axis, fed by the HPS speed/steps PIO words.
// Define STEPPER_ENDSTOP_EN to build in the endstop synchronizers and halt-on-endstop logic.
module stepper_pulse_gen #(
    parameter int unsigned PULSE_W   = 100,
    parameter int unsigned DIR_SETUP = 20
) (
    input  logic        clk_clk,
    input  logic        reset_reset,
    input  logic [31:0] speed,
    input  logic [31:0] steps_cmd,
    input  logic        cmd_toggle,
    input  logic        endstop_min,
    input  logic        endstop_max,
    output logic        step_out,
    output logic        dir_out,
    output logic [31:0] status
);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        HIGH,
        LOW
    } state_t;

    localparam logic [31:0] LP_PW_LAST    = 32'(PULSE_W - 1);
    localparam logic [31:0] LP_SETUP_LAST = 32'(DIR_SETUP - 1);
    localparam logic [31:0] LP_MIN_PER    = 32'(2 * PULSE_W);

    state_t      r_state, w_state_nxt;
    logic        r_tog_s, r_tog_q;
    logic [30:0] r_cmd_s;
    logic        r_dir, w_dir_nxt;
    logic [29:0] r_rem, w_rem_nxt;
    logic        r_busy, w_busy_nxt;
    logic        r_halted, w_halted_nxt;
    logic        r_step, w_step_nxt;
    logic [31:0] r_cnt, w_cnt_nxt;
    logic [31:0] r_per, w_per_nxt;
    logic        r_pend, w_pend_nxt;
    logic [30:0] r_pend_cmd, w_pend_cmd_nxt;

    logic        w_cmd_seen, w_cmd_zero, w_halt, w_low_done, w_load, w_unused;
    logic [30:0] w_load_cmd;
    logic [31:0] w_period, w_cnt_inc, w_per_inc;
    logic [29:0] w_rem_dec;

    // The toggle and its command word are registered together so the word is stable at detection.
    assign w_cmd_seen = r_tog_s ^ r_tog_q;
    assign w_cmd_zero = (r_cmd_s[29:0] == '0);
    assign w_period   = (speed > LP_MIN_PER) ? speed : LP_MIN_PER;
    assign w_low_done = (r_cnt >= LP_PW_LAST);
    assign w_cnt_inc  = r_cnt + 32'd1;
    assign w_per_inc  = (r_per == '1) ? r_per : r_per + 32'd1;
    assign w_rem_dec  = (r_rem == '0) ? '0 : r_rem - 30'd1;

`ifdef STEPPER_ENDSTOP_EN
    logic r_min_s1, r_min_s2, r_max_s1, r_max_s2;

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            r_min_s1 <= 1'b0;
            r_min_s2 <= 1'b0;
            r_max_s1 <= 1'b0;
            r_max_s2 <= 1'b0;
        end else begin
            r_min_s1 <= endstop_min;
            r_min_s2 <= r_min_s1;
            r_max_s1 <= endstop_max;
            r_max_s2 <= r_max_s1;
        end
    end

    assign w_halt   = r_dir ? r_max_s2 : r_min_s2;
    assign w_unused = steps_cmd[30];
`else
    assign w_halt   = 1'b0;
    assign w_unused = steps_cmd[30] ^ endstop_min ^ endstop_max;
`endif

    always_comb begin
        w_state_nxt    = r_state;
        w_dir_nxt      = r_dir;
        w_rem_nxt      = r_rem;
        w_busy_nxt     = r_busy;
        w_halted_nxt   = r_halted;
        w_step_nxt     = r_step;
        w_cnt_nxt      = r_cnt;
        w_per_nxt      = r_per;
        w_pend_nxt     = r_pend;
        w_pend_cmd_nxt = r_pend_cmd;
        w_load         = 1'b0;
        w_load_cmd     = r_cmd_s;

        case (r_state)
            IDLE: begin
                w_load = w_cmd_seen && !w_cmd_zero;
            end
            SETUP: begin
                if (w_cmd_seen && !w_cmd_zero) begin
                    w_load = 1'b1;
                end else if (r_pend) begin
                    w_load     = 1'b1;
                    w_load_cmd = r_pend_cmd;
                end else if (w_halt) begin
                    w_state_nxt  = IDLE;
                    w_busy_nxt   = 1'b0;
                    w_halted_nxt = 1'b1;
                end else if (r_cnt == LP_SETUP_LAST) begin
                    w_state_nxt = HIGH;
                    w_step_nxt  = 1'b1;
                    w_rem_nxt   = w_rem_dec;
                    w_cnt_nxt   = '0;
                    w_per_nxt   = 32'd1;
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                end
            end
            HIGH: begin
                w_per_nxt = w_per_inc;
                if (r_cnt == LP_PW_LAST) begin
                    w_state_nxt = LOW;
                    w_step_nxt  = 1'b0;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                end
            end
            LOW: begin
                // Period counter freezes while paused; every exit waits out the minimum low time.
                if (speed != '0) w_per_nxt = w_per_inc;
                if (!w_low_done) begin
                    w_cnt_nxt = w_cnt_inc;
                end else if (r_pend) begin
                    w_load     = 1'b1;
                    w_load_cmd = r_pend_cmd;
                end else if (w_halt) begin
                    w_state_nxt  = IDLE;
                    w_busy_nxt   = 1'b0;
                    w_halted_nxt = 1'b1;
                end else if (r_rem == '0) begin
                    w_state_nxt = IDLE;
                    w_busy_nxt  = 1'b0;
                end else if ((speed != '0) && (r_per >= w_period)) begin
                    w_state_nxt = HIGH;
                    w_step_nxt  = 1'b1;
                    w_rem_nxt   = w_rem_dec;
                    w_cnt_nxt   = '0;
                    w_per_nxt   = 32'd1;
                end
            end
            default: ;
        endcase

        if (w_load) begin
            w_state_nxt  = SETUP;
            w_dir_nxt    = w_load_cmd[30];
            w_rem_nxt    = w_load_cmd[29:0];
            w_busy_nxt   = 1'b1;
            w_halted_nxt = 1'b0;
            w_step_nxt   = 1'b0;
            w_cnt_nxt    = '0;
            w_pend_nxt   = 1'b0;
        end

        if (w_cmd_seen && !w_cmd_zero && ((r_state == HIGH) || (r_state == LOW))) begin
            w_pend_nxt     = 1'b1;
            w_pend_cmd_nxt = r_cmd_s;
        end

        // A zero-count command cancels everything; a move still in setup must not emit a pulse.
        if (w_cmd_seen && w_cmd_zero) begin
            w_rem_nxt    = '0;
            w_busy_nxt   = 1'b0;
            w_halted_nxt = 1'b0;
            w_pend_nxt   = 1'b0;
            if ((r_state == SETUP) || (w_state_nxt == SETUP)) begin
                w_state_nxt = IDLE;
                w_step_nxt  = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            r_state    <= IDLE;
            r_tog_s    <= 1'b0;
            r_tog_q    <= 1'b0;
            r_cmd_s    <= '0;
            r_dir      <= 1'b0;
            r_rem      <= '0;
            r_busy     <= 1'b0;
            r_halted   <= 1'b0;
            r_step     <= 1'b0;
            r_cnt      <= '0;
            r_per      <= '0;
            r_pend     <= 1'b0;
            r_pend_cmd <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_tog_s    <= cmd_toggle;
            r_tog_q    <= r_tog_s;
            r_cmd_s    <= {steps_cmd[31], steps_cmd[29:0]};
            r_dir      <= w_dir_nxt;
            r_rem      <= w_rem_nxt;
            r_busy     <= w_busy_nxt;
            r_halted   <= w_halted_nxt;
            r_step     <= w_step_nxt;
            r_cnt      <= w_cnt_nxt;
            r_per      <= w_per_nxt;
            r_pend     <= w_pend_nxt;
            r_pend_cmd <= w_pend_cmd_nxt;
        end
    end

    assign step_out = r_step;
    assign dir_out  = r_dir;
    assign status   = {r_busy, r_halted, r_rem};

endmodule

// File: tb/tb_stepper_pulse_gen.sv
// Bench for stepper_pulse_gen: randomized moves compared against a timeline model built from
// the period, pulse-width, setup and endstop-latency rules.
`timescale 1ns/1ps
module tb_stepper_pulse_gen;
    localparam int unsigned PW = 100;
    localparam int unsigned DS = 20;

    logic        clk = 1'b0;
    logic        reset_reset;
    logic [31:0] speed;
    logic [31:0] steps_cmd;
    logic        cmd_toggle;
    logic        endstop_min;
    logic        endstop_max;
    logic        step_out;
    logic        dir_out;
    logic [31:0] status;

    always #5 clk = ~clk;

    stepper_pulse_gen #(.PULSE_W(PW), .DIR_SETUP(DS)) dut (
        .clk_clk    (clk),
        .reset_reset(reset_reset),
        .speed      (speed),
        .steps_cmd  (steps_cmd),
        .cmd_toggle (cmd_toggle),
        .endstop_min(endstop_min),
        .endstop_max(endstop_max),
        .step_out   (step_out),
        .dir_out    (dir_out),
        .status     (status)
    );

    int unsigned cyc = 0;
    int unsigned rises[$], falls[$], dir_ev[$], busy_up[$], busy_dn[$];
    logic        p_step = 1'b0, p_dir = 1'b0, p_busy = 1'b0;
    int          n_tests = 0, n_fail = 0;

    // Event log: cyc is the number of the posedge whose result is being sampled.
    always begin
        @(posedge clk);
        cyc++;
        #1;
        if (step_out && !p_step) rises.push_back(cyc);
        if (!step_out && p_step) falls.push_back(cyc);
        if (dir_out !== p_dir) dir_ev.push_back(cyc);
        if (status[31] && !p_busy) busy_up.push_back(cyc);
        if (!status[31] && p_busy) busy_dn.push_back(cyc);
        p_step = step_out;
        p_dir  = dir_out;
        p_busy = status[31];
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic int unsigned qget(input int unsigned q[$], input int k);
        return (k < q.size()) ? q[k] : 0;
    endfunction

    function automatic int unsigned eff_period(input int unsigned spd);
        return (spd > 2 * PW) ? spd : 2 * PW;
    endfunction

    task automatic clear_logs();
        @(negedge clk);
        rises.delete();
        falls.delete();
        dir_ev.delete();
        busy_up.delete();
        busy_dn.delete();
    endtask

    task automatic send_cmd(input bit d, input int unsigned cnt, output int unsigned t);
        logic b30;
        @(negedge clk);
        b30        = 1'($urandom_range(0, 1));
        steps_cmd  = {d, b30, cnt[29:0]};
        cmd_toggle = ~cmd_toggle;
        t          = cyc;
    endtask

    // sel: 0 = STEP rises, 1 = STEP falls, 2 = busy falls
    task automatic wait_count(input int sel, input int n, input int budget, output bit ok);
        int got;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            got = (sel == 0) ? rises.size() : (sel == 1) ? falls.size() : busy_dn.size();
            if (got >= n) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset_reset = 1'b1;
        repeat (4) @(negedge clk);
        n_tests++;
        if (step_out !== 1'b0 || dir_out !== 1'b0 || status !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_state: step=%b dir=%b status=%h want 0 0 00000000",
                     step_out, dir_out, status);
        end
        reset_reset = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_moves();
        int unsigned spd, n, t, p, first, exp_r;
        bit d, ok;
        for (int i = 0; i < 7; i++) begin
            if (i == 0) begin
                spd = 1000; n = 5; d = 1'b1;
            end else if (i == 1) begin
                spd = 50; n = 3; d = 1'($urandom_range(0, 1));
            end else begin
                spd = $urandom_range(20, 400); n = $urandom_range(1, 4);
                d = 1'($urandom_range(0, 1));
            end
            speed = spd;
            clear_logs();
            send_cmd(d, n, t);
            p     = eff_period(spd);
            first = t + 2 + DS;
            wait_count(2, 1, DS + n * p + 3 * PW + 50, ok);
            n_tests++;
            if (ok !== 1'b1) begin
                n_fail++;
                $display("FAIL move%0d timeout: busy never dropped (speed %0d, n %0d)", i, spd, n);
            end
            n_tests++;
            if (qget(busy_up, 0) != t + 2) begin
                n_fail++;
                $display("FAIL move%0d busy_rise: got %0d want %0d", i, qget(busy_up, 0), t + 2);
            end
            n_tests++;
            if (dir_out !== d) begin
                n_fail++;
                $display("FAIL move%0d dir: got %b want %b", i, dir_out, d);
            end
            n_tests++;
            if (rises.size() != n) begin
                n_fail++;
                $display("FAIL move%0d pulse_count: got %0d want %0d", i, rises.size(), n);
            end
            for (int k = 0; k < int'(n); k++) begin
                exp_r = first + k * p;
                n_tests++;
                if (qget(rises, k) != exp_r || qget(falls, k) != exp_r + PW) begin
                    n_fail++;
                    $display("FAIL move%0d pulse%0d: rise %0d fall %0d want rise %0d fall %0d",
                             i, k, qget(rises, k), qget(falls, k), exp_r, exp_r + PW);
                end
            end
            n_tests++;
            if (qget(busy_dn, 0) != first + (n - 1) * p + 2 * PW || status !== 32'h0) begin
                n_fail++;
                $display("FAIL move%0d done: busy_fall %0d status %h want %0d 00000000",
                         i, qget(busy_dn, 0), status, first + (n - 1) * p + 2 * PW);
            end
        end
    endtask

    task automatic test_halt();
        int unsigned t, a, first, n_exp, idle, last, off;
        logic [31:0] st_exp;
        bit ok;
        speed = 200;
        clear_logs();
        send_cmd(1'b0, 100, t);
        first = t + 2 + DS;
        wait_count(0, 10, DS + 10 * 200 + 50, ok);
        off = $urandom_range(0, 199);
        repeat (off) @(negedge clk);
        a = cyc;
        endstop_min = 1'b1;
`ifdef STEPPER_ENDSTOP_EN
        n_exp = (a + 2 - first) / 200 + 1;
        if (n_exp > 100) n_exp = 100;
        last   = first + (n_exp - 1) * 200;
        idle   = (a + 3 > last + 2 * PW) ? a + 3 : last + 2 * PW;
        st_exp = 32'h4000_0000 | (100 - n_exp);
`else
        n_exp  = 100;
        idle   = first + 99 * 200 + 2 * PW;
        st_exp = 32'h0;
`endif
        wait_count(2, 1, 100 * 200 + 500, ok);
        n_tests++;
        if (ok !== 1'b1) begin
            n_fail++;
            $display("FAIL halt timeout: busy never dropped");
        end
        n_tests++;
        if (rises.size() != n_exp) begin
            n_fail++;
            $display("FAIL halt pulse_count: got %0d want %0d (endstop at %0d)", rises.size(), n_exp, a);
        end
        n_tests++;
        if (qget(busy_dn, 0) != idle || status !== st_exp) begin
            n_fail++;
            $display("FAIL halt stop: busy_fall %0d status %h want %0d %h",
                     qget(busy_dn, 0), status, idle, st_exp);
        end
        endstop_min = 1'b0;
        repeat (5) @(negedge clk);

        // endstop already active when the command loads
        endstop_max = 1'b1;
        clear_logs();
        repeat (4) @(negedge clk);
        send_cmd(1'b1, 2, t);
        wait_count(2, 1, DS + 2 * 200 + 3 * PW, ok);
        repeat (3) @(negedge clk);
`ifdef STEPPER_ENDSTOP_EN
        n_exp = 0; idle = t + 3; st_exp = 32'h4000_0002;
`else
        n_exp = 2; idle = t + 2 + DS + 200 + 2 * PW; st_exp = 32'h0;
`endif
        n_tests++;
        if (rises.size() != n_exp || qget(busy_dn, 0) != idle || status !== st_exp) begin
            n_fail++;
            $display("FAIL halt_at_load: pulses %0d busy_fall %0d status %h want %0d %0d %h",
                     rises.size(), qget(busy_dn, 0), status, n_exp, idle, st_exp);
        end
        endstop_max = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_dir_mask();
        int unsigned t, first;
        bit ok;
        speed = 200;
        endstop_max = 1'b1;
        clear_logs();
        send_cmd(1'b0, 100, t);
        first = t + 2 + DS;
        wait_count(2, 1, 100 * 200 + 500, ok);
        n_tests++;
        if (ok !== 1'b1 || rises.size() != 100) begin
            n_fail++;
            $display("FAIL dir_mask pulse_count: got %0d want 100", rises.size());
        end
        n_tests++;
        if (qget(busy_dn, 0) != first + 99 * 200 + 2 * PW || status !== 32'h0) begin
            n_fail++;
            $display("FAIL dir_mask done: busy_fall %0d status %h want %0d 00000000",
                     qget(busy_dn, 0), status, first + 99 * 200 + 2 * PW);
        end
        endstop_max = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_retarget();
        int unsigned t, t2, r2, base;
        bit ok;
        speed = 400;
        clear_logs();
        send_cmd(1'b1, 4, t);
        wait_count(0, 2, DS + 2 * 400 + 50, ok);
        r2 = qget(rises, 1);
        repeat ($urandom_range(0, 58)) @(negedge clk);
        send_cmd(1'b0, 3, t2);
        wait_count(2, 1, 3 * PW + DS + 3 * 400 + 100, ok);
        base = r2 + 2 * PW + DS;
        n_tests++;
        if (ok !== 1'b1 || rises.size() != 5) begin
            n_fail++;
            $display("FAIL retarget pulse_count: got %0d want 5", rises.size());
        end
        n_tests++;
        if (qget(falls, 1) != r2 + PW) begin
            n_fail++;
            $display("FAIL retarget width: fall %0d want %0d", qget(falls, 1), r2 + PW);
        end
        n_tests++;
        if (dir_ev.size() == 0 || dir_ev[dir_ev.size() - 1] != r2 + 2 * PW || dir_out !== 1'b0) begin
            n_fail++;
            $display("FAIL retarget dir_fall: got %0d dir %b want %0d 0",
                     (dir_ev.size() > 0) ? dir_ev[dir_ev.size() - 1] : 0, dir_out, r2 + 2 * PW);
        end
        for (int k = 0; k < 3; k++) begin
            n_tests++;
            if (qget(rises, k + 2) != base + k * 400) begin
                n_fail++;
                $display("FAIL retarget rise%0d: got %0d want %0d", k, qget(rises, k + 2), base + k * 400);
            end
        end
        n_tests++;
        if (status !== 32'h0) begin
            n_fail++;
            $display("FAIL retarget status: got %h want 00000000", status);
        end
    endtask

    task automatic test_pause();
        int unsigned t, r2, d, nxt;
        bit ok;
        speed = 400;
        clear_logs();
        send_cmd(1'b1, 6, t);
        wait_count(1, 2, DS + 2 * 400 + 50, ok);
        r2 = qget(rises, 1);
        speed = 0;
        d = 3 * $urandom_range(100, 250);
        for (int j = 0; j < 3; j++) begin
            repeat (d / 3) @(negedge clk);
            n_tests++;
            if (step_out !== 1'b0 || status !== 32'h8000_0004 || rises.size() != 2) begin
                n_fail++;
                $display("FAIL pause hold%0d: step %b status %h pulses %0d want 0 80000004 2",
                         j, step_out, status, rises.size());
            end
        end
        speed = 400;
        nxt = r2 + 400 + d;
        wait_count(2, 1, 5 * 400 + 3 * PW, ok);
        n_tests++;
        if (ok !== 1'b1 || rises.size() != 6) begin
            n_fail++;
            $display("FAIL pause pulse_count: got %0d want 6", rises.size());
        end
        n_tests++;
        if (qget(rises, 2) != nxt || qget(rises, 5) != nxt + 3 * 400) begin
            n_fail++;
            $display("FAIL pause resume: rise3 %0d rise6 %0d want %0d %0d",
                     qget(rises, 2), qget(rises, 5), nxt, nxt + 3 * 400);
        end
    endtask

    task automatic test_zero_count();
        int unsigned t;
        clear_logs();
        send_cmd(1'($urandom_range(0, 1)), 0, t);
        repeat (DS + 40) @(negedge clk);
        n_tests++;
        if (busy_up.size() != 0 || rises.size() != 0 || status !== 32'h0) begin
            n_fail++;
            $display("FAIL zero_count: busy_rises %0d pulses %0d status %h want 0 0 00000000",
                     busy_up.size(), rises.size(), status);
        end
    endtask

    task automatic test_reset_mid_high();
        int unsigned t;
        bit ok;
        speed = 400;
        clear_logs();
        send_cmd(1'b1, 3, t);
        wait_count(0, 1, DS + 50, ok);
        n_tests++;
        if (ok !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_mid timeout: no STEP rise");
        end
        repeat ($urandom_range(1, 50)) @(negedge clk);
        reset_reset = 1'b1;
        @(negedge clk);
        n_tests++;
        if (step_out !== 1'b0 || status !== 32'h0 || dir_out !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid: step %b status %h dir %b want 0 00000000 0",
                     step_out, status, dir_out);
        end
        cmd_toggle = 1'b0;
        steps_cmd  = 32'h0;
        repeat (2) @(negedge clk);
        reset_reset = 1'b0;
        repeat (DS + 10) @(negedge clk);
        n_tests++;
        if (step_out !== 1'b0 || status !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_after: step %b status %h want 0 00000000", step_out, status);
        end
    endtask

    initial begin
        reset_reset = 1'b1;
        speed       = 32'd0;
        steps_cmd   = 32'd0;
        cmd_toggle  = 1'b0;
        endstop_min = 1'b0;
        endstop_max = 1'b0;
        test_reset();
        test_moves();
        test_halt();
        test_dir_mask();
        test_retarget();
        test_pause();
        test_zero_count();
        test_reset_mid_high();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
